// File: rtl/dsm_pkg.sv
// Shared types for the delta-sigma sample scheduler: FSM state encoding and
// the occupancy-counter width helper used by the FIFO and the top.
package dsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } dsm_state_t;

  // Occupancy must represent 0..depth inclusive.
  function automatic int fill_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dsm_sample_fifo.sv
// Synchronous sample FIFO with a registered occupancy count. The head entry
// is read combinationally so a pop can land in the output register same-edge.
module dsm_sample_fifo
  import dsm_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                push,
  input  logic signed [DATA_WIDTH-1:0]        push_data,
  input  logic                                pop,
  output logic signed [DATA_WIDTH-1:0]        head,
  output logic [fill_width(DEPTH)-1:0]        count,
  output logic                                full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = fill_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_reg == FULL_CNT);
  assign push_ok = push && !full;
  assign pop_ok  = pop && (count_reg != '0);
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage carries no reset: pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dsm_sample_scheduler.sv
// Paces buffered samples into a delta-sigma modulator at one sample every
// (period+1) clocks, with priming, underflow detection and a sticky flag.
module dsm_sample_scheduler
  import dsm_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int OSR_WIDTH   = 8,
  parameter int PRIME_LEVEL = 2
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_enable,
  input  logic [OSR_WIDTH-1:0]                i_osr,
  input  logic                                i_clr_underflow,
  input  logic                                s_valid,
  input  logic signed [DATA_WIDTH-1:0]        s_data,
  output logic                                s_ready,
  output logic                                o_sample,
  output logic signed [DATA_WIDTH-1:0]        o_data,
  output logic [fill_width(FIFO_DEPTH)-1:0]   o_fill,
  output logic                                o_running,
  output logic                                o_underflow
);

  localparam int FILL_W = fill_width(FIFO_DEPTH);
  localparam logic [FILL_W-1:0] PRIME_CNT = FILL_W'(PRIME_LEVEL);

  dsm_state_t                   state_reg;
  logic [OSR_WIDTH-1:0]         period_reg;
  logic [OSR_WIDTH-1:0]         tick_cnt_reg;
  logic                         sample_reg;
  logic signed [DATA_WIDTH-1:0] data_reg;
  logic                         underflow_reg;

  logic [FILL_W-1:0]            fill;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic signed [DATA_WIDTH-1:0] head_data;
  logic                         push;
  logic                         pop;
  logic                         tick;

  assign s_ready    = !fifo_full;
  assign push       = s_valid && s_ready;
  assign fifo_empty = (fill == '0);
  // A disable on this edge wins over a tick, so the tick is gated by enable.
  assign tick       = (state_reg == ST_RUN) && i_enable && (tick_cnt_reg == period_reg);
  assign pop        = tick && !fifo_empty;

  assign o_sample    = sample_reg;
  assign o_data      = data_reg;
  assign o_fill      = fill;
  assign o_running   = (state_reg == ST_RUN);
  assign o_underflow = underflow_reg;

  dsm_sample_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head      (head_data),
    .count     (fill),
    .full      (fifo_full)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      period_reg    <= '0;
      tick_cnt_reg  <= '0;
      sample_reg    <= 1'b0;
      data_reg      <= '0;
      underflow_reg <= 1'b0;
    end else begin
      sample_reg <= 1'b0;

      if (tick && fifo_empty) begin
        underflow_reg <= 1'b1;
      end else if (i_clr_underflow) begin
        underflow_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (i_enable) begin
            state_reg  <= ST_PRIME;
            period_reg <= i_osr;
          end
        end
        ST_PRIME: begin
          if (!i_enable) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
          end else if (fill >= PRIME_CNT) begin
            state_reg    <= ST_RUN;
            tick_cnt_reg <= '0;
          end
        end
        ST_RUN: begin
          if (!i_enable) begin
            state_reg <= ST_IDLE;
            data_reg  <= '0;
          end else begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
            if (tick) begin
              sample_reg <= 1'b1;
              // An empty tick still strobes the modulator, with zero data,
              // and drops back to PRIME to rebuild the buffer.
              if (fifo_empty) begin
                data_reg  <= '0;
                state_reg <= ST_PRIME;
              end else begin
                data_reg <= head_data;
              end
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsm_sample_scheduler.sv
// Directed bench for dsm_sample_scheduler: expected modulator strobes are
// queued by the stimulus and matched by an independent negedge monitor.
module tb_dsm_sample_scheduler;

  localparam int DW = 4;
  localparam int FW = 3;

  typedef struct {
    int cyc;
    int data;
    int uf;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 enable;
  logic [7:0]           osr;
  logic                 clr_uf;
  logic                 s_valid;
  logic signed [DW-1:0] s_data;
  logic                 s_ready;
  logic                 o_sample;
  logic signed [DW-1:0] o_data;
  logic [FW-1:0]        o_fill;
  logic                 o_running;
  logic                 o_underflow;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  dsm_sample_scheduler #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (4),
    .OSR_WIDTH   (8),
    .PRIME_LEVEL (2)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_enable        (enable),
    .i_osr           (osr),
    .i_clr_underflow (clr_uf),
    .s_valid         (s_valid),
    .s_data          (s_data),
    .s_ready         (s_ready),
    .o_sample        (o_sample),
    .o_data          (o_data),
    .o_fill          (o_fill),
    .o_running       (o_running),
    .o_underflow     (o_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic step_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_sample) begin
        if (sb.size() == 0) begin
          check("unexpected_sample", int'(o_sample), 0);
        end else begin
          e = sb.pop_front();
          check("sample_cycle", cyc, e.cyc);
          check("sample_data", int'(o_data), e.data);
          check("sample_underflow", int'(o_underflow), e.uf);
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        check("missing_sample", int'(o_sample), 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    enable  = 1'b0;
    osr     = 8'd0;
    clr_uf  = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;

    // Reset values
    step();
    check("rst_sample", int'(o_sample), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_underflow", int'(o_underflow), 0);
    check("rst_running", int'(o_running), 0);
    check("rst_fill", int'(o_fill), 0);
    check("rst_ready", int'(s_ready), 1);
    rst_n = 1'b1;
    step();

    // osr=3: two preloaded samples, one strobe every 4 clocks
    s_valid = 1'b1; s_data = DW'(5);  step();
    s_data = DW'(-3); step();
    s_valid = 1'b0;
    check("fill_two", int'(o_fill), 2);
    osr = 8'd3; enable = 1'b1; n = cyc;
    sb.push_back('{n + 6, 5, 0});
    sb.push_back('{n + 10, -3, 0});
    step_to(n + 1); check("prime_not_running", int'(o_running), 0);
    step_to(n + 2); check("run_entered", int'(o_running), 1);
    step_to(n + 11);
    check("data_hold", int'(o_data), -3);
    check("fill_drained", int'(o_fill), 0);
    enable = 1'b0;
    step_to(n + 12);
    check("disable_data", int'(o_data), 0);
    check("disable_running", int'(o_running), 0);

    // Fill to full, fifth sample held, then osr=0 drains back-to-back
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1'b1; s_data = DW'(i); step();
    end
    s_data = DW'(7);
    check("full_ready", int'(s_ready), 0);
    check("full_fill", int'(o_fill), 4);
    step();
    check("full_held_ready", int'(s_ready), 0);
    check("full_held_fill", int'(o_fill), 4);
    osr = 8'd0; enable = 1'b1; n = cyc;
    sb.push_back('{n + 3, 1, 0});
    sb.push_back('{n + 4, 2, 0});
    sb.push_back('{n + 5, 3, 0});
    sb.push_back('{n + 6, 4, 0});
    sb.push_back('{n + 7, 7, 0});
    sb.push_back('{n + 8, 0, 1});
    step_to(n + 3); check("ready_after_pop", int'(s_ready), 1);
    step_to(n + 4);
    s_valid = 1'b0;
    check("fill_push_pop", int'(o_fill), 3);
    // Push and clear land on the same edge as the empty tick
    step_to(n + 7);
    s_valid = 1'b1; s_data = DW'(6); clr_uf = 1'b1;
    step_to(n + 8);
    s_valid = 1'b0; clr_uf = 1'b0;
    check("uf_set_wins", int'(o_underflow), 1);
    check("uf_push_stored", int'(o_fill), 1);
    check("uf_to_prime", int'(o_running), 0);
    step_to(n + 9);
    check("uf_sticky", int'(o_underflow), 1);
    clr_uf = 1'b1;
    step_to(n + 10);
    clr_uf = 1'b0;
    check("uf_cleared", int'(o_underflow), 0);
    enable = 1'b0;
    step_to(n + 11);
    check("idle_keeps_fifo", int'(o_fill), 1);

    // osr=2 latched at enable; later osr change ignored; drop enable mid-RUN
    s_valid = 1'b1; s_data = DW'(-2); step();
    s_data = DW'(3); step();
    s_valid = 1'b0;
    osr = 8'd2; enable = 1'b1; n = cyc;
    sb.push_back('{n + 5, 6, 0});
    step_to(n + 1);
    osr = 8'd0;
    step_to(n + 6);
    check("hold_before_drop", int'(o_data), 6);
    enable = 1'b0;
    step_to(n + 7);
    check("drop_sample", int'(o_sample), 0);
    check("drop_data", int'(o_data), 0);
    check("drop_running", int'(o_running), 0);
    check("drop_fill", int'(o_fill), 2);

    // Async reset while a strobe is high
    osr = 8'd1; enable = 1'b1; n = cyc;
    sb.push_back('{n + 4, -2, 0});
    step_to(n + 4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sample", int'(o_sample), 0);
    check("arst_data", int'(o_data), 0);
    check("arst_running", int'(o_running), 0);
    check("arst_fill", int'(o_fill), 0);
    check("arst_ready", int'(s_ready), 1);
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("post_rst_prime", int'(o_running), 0);
    check("post_rst_fill", int'(o_fill), 0);

    // Re-prime after reset with the osr=1 captured on the release
    n = cyc;
    s_valid = 1'b1; s_data = DW'(4); step();
    s_data = DW'(-5); step();
    s_valid = 1'b0;
    sb.push_back('{n + 5, 4, 0});
    sb.push_back('{n + 7, -5, 0});
    step_to(n + 8);
    enable = 1'b0;
    step_to(n + 10);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
